// File: rtl/bounded_loop_counter_pkg.sv
// Purpose: shared constants for the bounded two-variable counting loop and its checkers.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bounded_loop_counter_pkg;

  // Default loop geometry: i climbs from 1 by 2, j falls from 20 by 1.
  localparam int unsigned DEF_WIDTH  = 15;
  localparam int unsigned DEF_I_INIT = 1;
  localparam int unsigned DEF_J_INIT = 20;
  localparam int unsigned DEF_I_STEP = 2;
  localparam int unsigned DEF_J_STEP = 1;

  // With the defaults the loop exits after 7 iterations at (15,13).
  localparam int unsigned J_FINAL    = 13;
  localparam int unsigned I_FINAL    = 15;

  // i*J_STEP + j*I_STEP never changes across an iteration; with the defaults it is 41.
  localparam int unsigned INV_SUM    = DEF_I_INIT * DEF_J_STEP + DEF_J_INIT * DEF_I_STEP;

endpackage : bounded_loop_counter_pkg

// File: rtl/bounded_loop_counter_cond.sv
// Purpose: loop condition j >= i as an unsigned WIDTH-bit compare.
// Latency: combinational.
// Backpressure: none.
module loop_cond #(
  parameter int unsigned WIDTH = 15
) (
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] j,
  output logic             cond
);

  // The loop keeps iterating while j has not dropped below i.
  always_comb begin
    cond = (j >= i);
  end

endmodule : loop_cond

// File: rtl/bounded_loop_counter_sva.sv
// Purpose: assertion checker for the loop invariants, hold behaviour and exit state.
// Latency: observes state one edge after the cause (|=>); no outputs.
// Backpressure: none; purely observational.
module bounded_loop_counter_sva
  import bounded_loop_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned I_INIT = DEF_I_INIT,
  parameter int unsigned J_INIT = DEF_J_INIT,
  parameter int unsigned I_STEP = DEF_I_STEP,
  parameter int unsigned J_STEP = DEF_J_STEP
) (
  input logic             clk,
  input logic             rst,
  input logic             selector,
  input logic [WIDTH-1:0] i,
  input logic [WIDTH-1:0] j,
  input logic             done
);

  localparam logic [WIDTH-1:0] I_STEP_W  = WIDTH'(I_STEP);
  localparam logic [WIDTH-1:0] J_STEP_W  = WIDTH'(J_STEP);
  localparam logic [WIDTH-1:0] WSUM_INIT = WIDTH'(I_INIT * J_STEP + J_INIT * I_STEP);

  logic             cond;
  logic [WIDTH-1:0] wsum;

  loop_cond #(.WIDTH(WIDTH)) u_cond (
    .i    (i),
    .j    (j),
    .cond (cond)
  );

  // Weighted sum that each iteration leaves unchanged (modulo 2^WIDTH).
  always_comb begin
    wsum = i * J_STEP_W + j * I_STEP_W;
  end

  // Parameter-independent checks; reset cycles are excluded because state
  // before the first reset is unspecified.
  a_done_is_not_cond: assert property (@(posedge clk) disable iff (!rst)
    done == !cond);

  a_weighted_sum: assert property (@(posedge clk) disable iff (!rst)
    wsum == WSUM_INIT);

  a_hold_when_idle: assert property (@(posedge clk) disable iff (!rst)
    !selector |=> ($stable(i) && $stable(j)));

  a_absorbing_exit: assert property (@(posedge clk) disable iff (!rst)
    done |=> ($stable(i) && $stable(j)));

  a_step: assert property (@(posedge clk) disable iff (!rst)
    (selector && cond) |=> (i == $past(i) + I_STEP_W) && (j == $past(j) - J_STEP_W));

  // Invariants that are specific to the default trajectory (1,20)..(15,13).
  if (WIDTH == DEF_WIDTH && I_INIT == DEF_I_INIT && J_INIT == DEF_J_INIT &&
      I_STEP == DEF_I_STEP && J_STEP == DEF_J_STEP) begin : g_default_inv

    a_i_odd: assert property (@(posedge clk) disable iff (!rst)
      i[0] == 1'b1);

    a_j_floor: assert property (@(posedge clk) disable iff (!rst)
      j >= WIDTH'(J_FINAL));

    a_done_final: assert property (@(posedge clk) disable iff (!rst)
      done |-> (j == WIDTH'(J_FINAL)));

  end : g_default_inv

endmodule : bounded_loop_counter_sva

// File: rtl/bounded_loop_counter.sv
// Purpose: two-variable counting loop; i += I_STEP, j -= J_STEP per enabled cycle while j >= i.
// Latency: one cycle per iteration; done is combinational from the registers.
// Backpressure: none; selector gates iterations and may toggle every cycle.
module bounded_loop_counter
  import bounded_loop_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned I_INIT = DEF_I_INIT,
  parameter int unsigned J_INIT = DEF_J_INIT,
  parameter int unsigned I_STEP = DEF_I_STEP,
  parameter int unsigned J_STEP = DEF_J_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] j,
  output logic             done
);

  localparam logic [WIDTH-1:0] I_INIT_W = WIDTH'(I_INIT);
  localparam logic [WIDTH-1:0] J_INIT_W = WIDTH'(J_INIT);
  localparam logic [WIDTH-1:0] I_STEP_W = WIDTH'(I_STEP);
  localparam logic [WIDTH-1:0] J_STEP_W = WIDTH'(J_STEP);

  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic             cond;

  loop_cond #(.WIDTH(WIDTH)) u_cond (
    .i    (i_q),
    .j    (j_q),
    .cond (cond)
  );

  // Next state: iterate only when enabled and the loop has not exited; wrap freely.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (selector && cond) begin
      i_d = i_q + I_STEP_W;
      j_d = j_q - J_STEP_W;
    end
  end

  // State registers; reset takes priority over an iteration in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_q <= I_INIT_W;
      j_q <= J_INIT_W;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign done = ~cond;

  bounded_loop_counter_sva #(
    .WIDTH  (WIDTH),
    .I_INIT (I_INIT),
    .J_INIT (J_INIT),
    .I_STEP (I_STEP),
    .J_STEP (J_STEP)
  ) u_sva (
    .clk      (clk),
    .rst      (rst),
    .selector (selector),
    .i        (i_q),
    .j        (j_q),
    .done     (done)
  );

endmodule : bounded_loop_counter

// File: tb/tb_bounded_loop_counter.sv
// Purpose: directed bench for bounded_loop_counter (default and a narrow wrapping instance).
// Latency: samples 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_bounded_loop_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        selector;
  logic [14:0] i;
  logic [14:0] j;
  logic        done;

  logic        rst_w;
  logic        sel_w;
  logic [3:0]  i_w;
  logic [3:0]  j_w;
  logic        done_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bounded_loop_counter dut (
    .clk      (clk),
    .rst      (rst),
    .selector (selector),
    .i        (i),
    .j        (j),
    .done     (done)
  );

  bounded_loop_counter #(
    .WIDTH  (4),
    .I_INIT (14),
    .J_INIT (15)
  ) dut_w (
    .clk      (clk),
    .rst      (rst_w),
    .selector (sel_w),
    .i        (i_w),
    .j        (j_w),
    .done     (done_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int ei, input int ej, input int ed);
    chk({tag, ".i"}, int'(i), ei);
    chk({tag, ".j"}, int'(j), ej);
    chk({tag, ".done"}, int'(done), ed);
  endtask

  // Hand-computed continuous-enable trajectory after edges 1..10.
  int cont_i [10] = '{3, 5, 7, 9, 11, 13, 15, 15, 15, 15};
  int cont_j [10] = '{19, 18, 17, 16, 15, 14, 13, 13, 13, 13};
  int cont_d [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  // Gated enable pattern 1,0,0,1,0 and its expected states.
  logic gate_s [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int   gate_i [5] = '{3, 3, 3, 5, 5};
  int   gate_j [5] = '{19, 19, 19, 18, 18};

  // Narrow instance: 14+2 wraps to 0; j 15 -> 14 -> ... ; exits at (10,9).
  int wrap_i [5] = '{0, 2, 4, 6, 8};
  int wrap_j [5] = '{14, 13, 12, 11, 10};

  int mi, mj;
  logic s;

  initial begin
    rst      = 1'b0;
    selector = 1'b0;
    rst_w    = 1'b0;
    sel_w    = 1'b0;

    // Reset held for two edges.
    step();
    step();
    chk_state("reset", 1, 20, 0);

    // Continuous enable for 10 edges.
    rst      = 1'b1;
    selector = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_state($sformatf("cont%0d", k + 1), cont_i[k], cont_j[k], cont_d[k]);
    end

    // Gated enable from reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      selector = gate_s[k];
      step();
      chk_state($sformatf("gate%0d", k), gate_i[k], gate_j[k], 0);
    end

    // Mid-loop reset with selector high: reset wins.
    rst      = 1'b0;
    selector = 1'b0;
    step();
    rst      = 1'b1;
    selector = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk_state("mid_pre", 9, 16, 0);
    rst = 1'b0;
    step();
    chk_state("mid_rst", 1, 20, 0);

    // Random selector with invariant checks every cycle.
    rst      = 1'b1;
    mi       = 1;
    mj       = 20;
    for (int k = 0; k < 1000; k++) begin
      s        = 1'($urandom_range(0, 1));
      selector = s;
      step();
      if (s && (mj >= mi)) begin
        mi = mi + 2;
        mj = mj - 1;
      end
      chk("rand.i_odd", int'(i[0]), 1);
      chk("rand.sum41", int'(i) + 2 * int'(j), 41);
      chk("rand.model_i", int'(i), mi);
      chk("rand.model_j", int'(j), mj);
    end
    selector = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk_state("rand_final", 15, 13, 1);
    selector = 1'b0;

    // Narrow instance: wrap on the first iteration, then iteration continues.
    step();
    rst_w = 1'b1;
    sel_w = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("wrap%0d.i", k), int'(i_w), wrap_i[k]);
      chk($sformatf("wrap%0d.j", k), int'(j_w), wrap_j[k]);
      chk($sformatf("wrap%0d.done", k), int'(done_w), 0);
    end
    step();
    chk("wrap_exit.i", int'(i_w), 10);
    chk("wrap_exit.j", int'(j_w), 9);
    chk("wrap_exit.done", int'(done_w), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bounded_loop_counter

// File: doc/bounded_loop_counter.md
# bounded_loop_counter

Hardware rendering of a two-variable counting loop (`i` climbs by 2 and `j` falls by 1 while `j >= i`), used as a small arithmetic case for property and invariant mining. One iteration per enabled clock. A free input `selector` decides whether an iteration occurs in a given cycle. The block is the `top` of its case; there is no surrounding datapath.

## Interface
Parameters:
- `WIDTH`, 15: width of `i` and `j`.
- `I_INIT`, 1: reset value of `i`.
- `J_INIT`, 20: reset value of `j`.
- `I_STEP`, 2: increment applied to `i` per iteration.
- `J_STEP`, 1: decrement applied to `j` per iteration.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `selector`  in  1: iteration enable, sampled at the rising edge.
- `i`  out  WIDTH: loop variable `i`, registered.
- `j`  out  WIDTH: loop variable `j`, registered.
- `done`  out  1: high when the loop condition is false (`j < i`). Combinational from the registers.

## Operation
- Loop condition: `cond = (j >= i)`, an unsigned WIDTH-bit compare.
- Each rising edge is handled in this priority order:
  - If `rst == 0`: `i <= I_INIT`, `j <= J_INIT`.
  - Else if `selector == 1` and `cond`: `i <= i + I_STEP`, `j <= j - J_STEP`. Both use modulo 2^WIDTH arithmetic.
  - Else: `i` and `j` hold.
- Once `cond` is false, the state is absorbing: further `selector` pulses have no effect until reset.
- `done = ~cond`.
- Trajectory with default parameters: (1,20) (3,19) (5,18) (7,17) (9,16) (11,15) (13,14) (15,13).
  - This is 7 iterations, after which `done` = 1 with `i` = 15 and `j` = 13.
- Invariants that must hold at every cycle (default parameters):
  - `i` is odd.
  - `i + 2*j == 41`.
  - `j >= 13`.
  - `done` implies `j == 13`.
- Wrap-around: unreachable with the defaults; for other parameters the wrapped result is used, with no saturation.

## Timing
- All outputs are registered except `done`, which is combinational from `i` and `j`.
- Reset values: `i` = I_INIT (1), `j` = J_INIT (20), `done` = 0.
- Reset latency: outputs show the reset values from the first rising edge at which `rst` = 0 is sampled.
- Iteration latency: one cycle. A `selector` sampled high at edge k updates `i`/`j` visibly after edge k.
- Reset mid-loop: reset wins over `selector` in the same cycle, and state returns to the reset values at that edge.
- Power-up, before any reset: contents are unspecified. Benches must apply reset first.
- No handshake; `selector` may toggle every cycle.

## Structure
- Shared package holds `WIDTH` and the default constants `I_INIT`, `J_INIT`, `I_STEP`, `J_STEP`, plus the expected final `J_FINAL` = 13 used by checkers.
- The design is a single module with no sub-module required.
- Optionally, a `loop_cond` comparator sub-module producing `cond` from `i`/`j`, reused by the assertion bind.
- SVA in a bound checker module:
  - the invariants above;
  - `done |-> j == J_FINAL`;
  - hold when `!selector`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles -> `i` = 1, `j` = 20, `done` = 0.
- Continuous enable: release reset, `selector` = 1 for 10 cycles -> after the 7th edge `i` = 15, `j` = 13, `done` = 1; edges 8–10 leave the values unchanged.
- Gated enable: `selector` pattern 1,0,0,1,0 from reset -> (3,19), (3,19), (3,19), (5,18), (5,18).
- Mid-loop reset: iterate to (9,16), then assert `rst` = 0 with `selector` = 1 -> next state (1,20).
- Random selector for 1000 cycles -> invariants hold every cycle (`i` odd, `i + 2j` = 41); final state (15,13) once 7 enables have occurred.
- Parameter override `WIDTH` = 4, `I_INIT` = 14, `J_INIT` = 15 with selector high -> (0,14) after one edge (wrap); `done` = 0 and iteration continues.
